// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Shares one data-memory port between the CPU and a DMA/loader,
//            with a bounded-starvation forced DMA slot.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpuRead,
    input  logic          cpuWrite,
    input  logic [AW-1:0] cpuAddr,
    input  logic [15:0]   cpuWData,
    output logic [15:0]   cpuRData,
    output logic          cpuStall,
    input  logic          dmaReq,
    input  logic          dmaWrite,
    input  logic [AW-1:0] dmaAddr,
    input  logic [15:0]   dmaWData,
    output logic          dmaGnt,
    output logic [15:0]   dmaRData,
    output logic          dmaValid,
    output logic          memRead,
    output logic          memWrite,
    output logic [AW-1:0] memAddr,
    output logic [15:0]   memWData,
    input  logic [15:0]   memRData
);

    localparam int                 c_cntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cntWidth-1:0] c_cntMax = c_cntWidth'(STARVE_LIMIT);
    localparam logic [c_cntWidth-1:0] c_cntPre = c_cntWidth'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        c_ARB   = 1'b0,
        c_FORCE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [c_cntWidth-1:0]   r_starveCnt;
    logic [c_cntWidth-1:0]   w_cntNext;
    logic                    w_cpuReq;
    logic                    w_inForce;
    logic                    w_dmaSel;
    logic                    w_cpuSel;
    logic                    w_starved;

    assign cpuRData = memRData;

    // While reset is held the block behaves as ARB regardless of the stored state.
    always_comb begin
        w_cpuReq    = cpuRead | cpuWrite;
        w_inForce   = (r_state == c_FORCE) && reset;
        w_dmaSel    = dmaReq && (w_inForce || !w_cpuReq);
        w_cpuSel    = w_cpuReq && !w_dmaSel;
        w_starved   = dmaReq && !w_dmaSel;

        memRead     = 1'b0;
        memWrite    = 1'b0;
        memAddr     = '0;
        memWData    = '0;
        dmaGnt      = w_dmaSel;
        cpuStall    = w_inForce && dmaReq;

        if (w_dmaSel) begin
            memRead  = ~dmaWrite;
            memWrite = dmaWrite;
            memAddr  = dmaAddr;
            memWData = dmaWData;
        end else if (w_cpuSel) begin
            memRead  = cpuRead & ~cpuWrite;
            memWrite = cpuWrite;
            memAddr  = cpuAddr;
            memWData = cpuWData;
        end

        if (!w_starved) begin
            w_cntNext = '0;
        end else if (r_starveCnt == c_cntMax) begin
            w_cntNext = r_starveCnt;
        end else begin
            w_cntNext = r_starveCnt + 1'b1;
        end

        w_stateNext = c_ARB;
        case (r_state)
            c_ARB:   w_stateNext = (w_starved && (r_starveCnt == c_cntPre)) ? c_FORCE : c_ARB;
            c_FORCE: w_stateNext = c_ARB;
            default: w_stateNext = c_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ARB;
            r_starveCnt <= '0;
            dmaValid    <= 1'b0;
            dmaRData    <= 16'h0000;
        end else begin
            r_state     <= w_stateNext;
            r_starveCnt <= w_cntNext;
            dmaValid    <= w_dmaSel && !dmaWrite;
            if (w_dmaSel && !dmaWrite) begin
                dmaRData <= memRData;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Directed vectors, corner sequences and a randomized run against
//            a behavioural model of the data-memory arbiter.
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuRead, cpuWrite, dmaReq, dmaWrite;
    logic [15:0] cpuAddr, cpuWData, dmaAddr, dmaWData, memRData;
    logic [15:0] cpuRData, dmaRData, memAddr, memWData;
    logic        cpuStall, dmaGnt, dmaValid, memRead, memWrite;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter #(.STARVE_LIMIT(LIM), .AW(16)) dut (
        .clk(clk), .reset(reset),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuRData(cpuRData), .cpuStall(cpuStall),
        .dmaReq(dmaReq), .dmaWrite(dmaWrite), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
        .dmaGnt(dmaGnt), .dmaRData(dmaRData), .dmaValid(dmaValid),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, cRd, cWr;
        logic [15:0] cAddr, cWd;
        logic        dReq, dWr;
        logic [15:0] dAddr, dWd, mRd;
        logic        eRd, eWr;
        logic [15:0] eAddr, eWd;
        logic        eStall, eGnt, eValid;
        logic [15:0] eDRd;
    } vec_t;

    vec_t tbl[9];

    // Behavioural model state: forced-slot pending, denied-streak length, read-back register.
    bit          mForce;
    int          mStreak;
    bit          mValid;
    logic [15:0] mRData;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic rst, input logic cRd, input logic cWr,
                         input logic [15:0] cAddr, input logic [15:0] cWd,
                         input logic dReq, input logic dWr,
                         input logic [15:0] dAddr, input logic [15:0] dWd,
                         input logic [15:0] mRd);
        reset = rst; cpuRead = cRd; cpuWrite = cWr; cpuAddr = cAddr; cpuWData = cWd;
        dmaReq = dReq; dmaWrite = dWr; dmaAddr = dAddr; dmaWData = dWd; memRData = mRd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Who owns the port this cycle, derived from the arbitration rules.
    task automatic modelCheck(input string tag);
        bit inForce, dmaWins, cpuWins;
        logic eRd, eWr;
        logic [15:0] eAddr, eWd;
        inForce = mForce && (reset == 1'b1);
        dmaWins = dmaReq && (inForce || !(cpuRead || cpuWrite));
        cpuWins = !dmaWins && (cpuRead || cpuWrite);
        eRd = 0; eWr = 0; eAddr = 0; eWd = 0;
        if (dmaWins) begin
            eRd = !dmaWrite; eWr = dmaWrite; eAddr = dmaAddr; eWd = dmaWData;
        end else if (cpuWins) begin
            eWr = cpuWrite; eRd = !cpuWrite; eAddr = cpuAddr; eWd = cpuWData;
        end
        chk({tag, " memRead"},  32'(memRead),  32'(eRd));
        chk({tag, " memWrite"}, 32'(memWrite), 32'(eWr));
        chk({tag, " memAddr"},  32'(memAddr),  32'(eAddr));
        chk({tag, " memWData"}, 32'(memWData), 32'(eWd));
        chk({tag, " dmaGnt"},   32'(dmaGnt),   32'(dmaWins));
        chk({tag, " cpuStall"}, 32'(cpuStall), 32'(inForce && dmaReq));
        chk({tag, " cpuRData"}, 32'(cpuRData), 32'(memRData));
        chk({tag, " dmaValid"}, 32'(dmaValid), 32'(mValid));
        chk({tag, " dmaRData"}, 32'(dmaRData), 32'(mRData));
    endtask

    task automatic modelStep();
        bit inForce, dmaWins;
        int streak;
        if (reset == 1'b0) begin
            mForce = 0; mStreak = 0; mValid = 0; mRData = 16'h0000;
        end else begin
            inForce = mForce;
            dmaWins = dmaReq && (inForce || !(cpuRead || cpuWrite));
            mValid  = dmaWins && !dmaWrite;
            if (mValid) mRData = memRData;
            streak  = (dmaReq && !dmaWins) ? ((mStreak + 1 > LIM) ? LIM : mStreak + 1) : 0;
            mForce  = !inForce && (streak == LIM) && (mStreak < LIM);
            mStreak = streak;
        end
    endtask

    initial begin
        //             rst cRd cWr cAddr     cWd       dReq dWr dAddr     dWd       mRd       eRd eWr eAddr     eWd       eSt eGnt eVal eDRd
        tbl[0] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000};
        tbl[1] = '{1'b1,1'b1,1'b0,16'h0010,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF,1'b1,1'b0,16'h0010,16'h0000,1'b0,1'b0,1'b0,16'h0000};
        tbl[2] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0200,16'h0000,16'h1234,1'b1,1'b0,16'h0200,16'h0000,1'b0,1'b1,1'b0,16'h0000};
        tbl[3] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'h5555,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'h1234};
        tbl[4] = '{1'b1,1'b1,1'b1,16'h0044,16'hA5A5,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,16'h0044,16'hA5A5,1'b0,1'b0,1'b0,16'h1234};
        tbl[5] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0300,16'h7777,16'h0000,1'b0,1'b1,16'h0300,16'h7777,1'b0,1'b1,1'b0,16'h1234};
        tbl[6] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h1234};
        tbl[7] = '{1'b1,1'b0,1'b1,16'h0055,16'h1111,1'b1,1'b0,16'h0400,16'h0000,16'h0000,1'b0,1'b1,16'h0055,16'h1111,1'b0,1'b0,1'b0,16'h1234};
        tbl[8] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h1234};

        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        for (int i = 0; i < 9; i++) begin
            setIn(tbl[i].rst, tbl[i].cRd, tbl[i].cWr, tbl[i].cAddr, tbl[i].cWd,
                  tbl[i].dReq, tbl[i].dWr, tbl[i].dAddr, tbl[i].dWd, tbl[i].mRd);
            #3;
            chk($sformatf("vec%0d memRead", i),  32'(memRead),  32'(tbl[i].eRd));
            chk($sformatf("vec%0d memWrite", i), 32'(memWrite), 32'(tbl[i].eWr));
            chk($sformatf("vec%0d memAddr", i),  32'(memAddr),  32'(tbl[i].eAddr));
            chk($sformatf("vec%0d memWData", i), 32'(memWData), 32'(tbl[i].eWd));
            chk($sformatf("vec%0d cpuStall", i), 32'(cpuStall), 32'(tbl[i].eStall));
            chk($sformatf("vec%0d dmaGnt", i),   32'(dmaGnt),   32'(tbl[i].eGnt));
            chk($sformatf("vec%0d cpuRData", i), 32'(cpuRData), 32'(tbl[i].mRd));
            chk($sformatf("vec%0d dmaValid", i), 32'(dmaValid), 32'(tbl[i].eValid));
            chk($sformatf("vec%0d dmaRData", i), 32'(dmaRData), 32'(tbl[i].eDRd));
            step();
        end

        // Starvation: 8 denied cycles, forced DMA write on the 9th, CPU back on the 10th.
        setIn(1, 1, 0, 16'h0020, 16'h0000, 1, 1, 16'h0600, 16'hCAFE, 16'h0000);
        for (int i = 1; i <= LIM; i++) begin
            #3;
            chk($sformatf("starve%0d dmaGnt", i),   32'(dmaGnt),   32'd0);
            chk($sformatf("starve%0d cpuStall", i), 32'(cpuStall), 32'd0);
            step();
        end
        #3;
        chk("force cpuStall", 32'(cpuStall), 32'd1);
        chk("force dmaGnt",   32'(dmaGnt),   32'd1);
        chk("force memWrite", 32'(memWrite), 32'd1);
        chk("force memRead",  32'(memRead),  32'd0);
        chk("force memAddr",  32'(memAddr),  32'h0600);
        chk("force memWData", 32'(memWData), 32'hCAFE);
        step();
        #3;
        chk("after force cpuStall", 32'(cpuStall), 32'd0);
        chk("after force dmaGnt",   32'(dmaGnt),   32'd0);
        chk("after force memAddr",  32'(memAddr),  32'h0020);
        chk("after force memRead",  32'(memRead),  32'd1);
        step();
        dmaReq = 0;
        step();

        // DMA withdraws on the forced cycle.
        setIn(1, 1, 0, 16'h0030, 16'h0000, 1, 1, 16'h0610, 16'h0001, 16'h0000);
        for (int i = 1; i <= LIM; i++) step();
        dmaReq = 0;
        #3;
        chk("withdraw cpuStall", 32'(cpuStall), 32'd0);
        chk("withdraw dmaGnt",   32'(dmaGnt),   32'd0);
        chk("withdraw memRead",  32'(memRead),  32'd1);
        chk("withdraw memAddr",  32'(memAddr),  32'h0030);
        step();
        dmaReq = 1;
        #3;
        chk("withdraw back-to-arb cpuStall", 32'(cpuStall), 32'd0);
        chk("withdraw back-to-arb dmaGnt",   32'(dmaGnt),   32'd0);
        step();
        dmaReq = 0;
        step();

        // Reset while in FORCE with a DMA read pending.
        setIn(1, 1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0700, 16'h0000, 16'h9999);
        for (int i = 1; i <= LIM; i++) step();
        reset = 0;
        #3;
        chk("reset-in-force cpuStall", 32'(cpuStall), 32'd0);
        chk("reset-in-force dmaGnt",   32'(dmaGnt),   32'd0);
        step();
        reset = 1;
        #3;
        chk("post-reset cpuStall", 32'(cpuStall), 32'd0);
        chk("post-reset dmaValid", 32'(dmaValid), 32'd0);
        chk("post-reset dmaRData", 32'(dmaRData), 32'h0000);
        chk("post-reset dmaGnt",   32'(dmaGnt),   32'd0);
        step();
        for (int i = 2; i <= LIM; i++) begin
            #3;
            chk($sformatf("post-reset starve%0d cpuStall", i), 32'(cpuStall), 32'd0);
            step();
        end
        #3;
        chk("post-reset force cpuStall", 32'(cpuStall), 32'd1);
        chk("post-reset force memRead",  32'(memRead),  32'd1);
        chk("post-reset force memAddr",  32'(memAddr),  32'h0700);
        step();
        #3;
        chk("forced read dmaValid", 32'(dmaValid), 32'd1);
        chk("forced read dmaRData", 32'(dmaRData), 32'h9999);
        step();

        // Randomized run against the model.
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelStep();
        step();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 63) != 0);
            cpuRead  = ($urandom_range(0, 9) < 7);
            cpuWrite = ($urandom_range(0, 3) == 0);
            cpuAddr  = 16'($urandom);
            cpuWData = 16'($urandom);
            if (!dmaReq) begin
                dmaReq   = ($urandom_range(0, 3) == 0);
                dmaWrite = 1'($urandom);
                dmaAddr  = 16'($urandom);
                dmaWData = 16'($urandom);
            end else if (dmaGnt || $urandom_range(0, 15) == 0) begin
                dmaReq = 0;
            end
            memRData = 16'($urandom);
            #3;
            modelCheck($sformatf("rnd%0d", i));
            modelStep();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: number of consecutive denied DMA cycles before a forced DMA slot.
REQ-002 The block SHALL have parameter AW, default 16: address width.
REQ-003 The block SHALL have ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cpuRead  in  1  processor data-port read request (MRAfterE2M).
- cpuWrite  in  1  processor data-port write request (MWAfterE2M).
- cpuAddr  in  AW  processor data address (dataMemAddr).
- cpuWData  in  16  processor write data (writeMemData).
- cpuRData  out  16  read data returned to processor (memData).
- cpuStall  out  1  processor must hold its memory stage this cycle.
- dmaReq  in  1  DMA/loader access request, level-held until granted.
- dmaWrite  in  1  1 = DMA write, 0 = DMA read; valid with dmaReq.
- dmaAddr  in  AW  DMA address.
- dmaWData  in  16  DMA write data.
- dmaGnt  out  1  DMA access performed this cycle.
- dmaRData  out  16  registered DMA read data.
- dmaValid  out  1  dmaRData valid; one-cycle pulse.
- memRead  out  1  data memory read enable.
- memWrite  out  1  data memory write enable.
- memAddr  out  AW  data memory address.
- memWData  out  16  data memory write data.
- memRData  in  16  data memory read data; combinational, same cycle as memAddr.

Function
REQ-004 The block SHALL implement a two-state FSM, ARB and FORCE, plus a saturating starvation counter starveCnt of width ceil(log2(STARVE_LIMIT+1)).
REQ-005 In ARB, when cpuRead or cpuWrite is 1, the memory port SHALL carry the CPU access combinationally, with dmaGnt=0 and cpuStall=0.
REQ-006 In ARB, when the CPU is idle and dmaReq=1, the memory port SHALL carry the DMA access and dmaGnt SHALL be 1.
REQ-007 If cpuRead and cpuWrite are both 1, the access SHALL be treated as a write: memWrite=1, memRead=0.
REQ-008 For a DMA access, memRead SHALL equal ~dmaWrite and memWrite SHALL equal dmaWrite.
REQ-009 When no access is granted, memRead, memWrite, memAddr and memWData SHALL be 0.
REQ-010 cpuRData SHALL equal memRData in every cycle, unregistered.
REQ-011 starveCnt SHALL increment each cycle where dmaReq=1 and dmaGnt=0, saturating at STARVE_LIMIT.
REQ-012 starveCnt SHALL clear to 0 on any cycle with dmaGnt=1 or dmaReq=0.
REQ-013 The FSM SHALL move ARB->FORCE on the edge where starveCnt would reach STARVE_LIMIT.
REQ-014 In FORCE with dmaReq=1: cpuStall=1, the DMA access SHALL drive the memory port, dmaGnt=1, and the CPU request SHALL be ignored.
REQ-015 In FORCE with dmaReq=0 (DMA withdrew): cpuStall=0 and the CPU SHALL be served as in ARB.
REQ-016 FORCE SHALL always return to ARB after exactly one cycle, so at most one CPU stall cycle occurs per STARVE_LIMIT window.
REQ-017 On a cycle with dmaGnt=1 and dmaWrite=0, dmaRData SHALL register memRData and dmaValid SHALL pulse 1 on the following cycle.
REQ-018 dmaValid SHALL be 0 in all other cycles.
REQ-019 dmaRData SHALL hold its last value when dmaValid=0.
REQ-020 Address arithmetic SHALL be pass-through only; no wrap or offset is applied.

Reset
REQ-021 While reset=0 at a clk edge, the block SHALL set state=ARB, starveCnt=0, dmaValid=0 and dmaRData=16'h0000.
REQ-022 A reset in FORCE SHALL return the block to ARB with cpuStall=0 on the next cycle, and no dmaValid pulse SHALL follow.
REQ-023 During reset, combinational outputs SHALL follow ARB rules using the reset state values.

Verification
REQ-024 CPU-only access: cpuRead=1, cpuAddr=16'h0010, memRData=16'hBEEF -> memRead=1, memAddr=16'h0010, cpuRData=16'hBEEF, cpuStall=0.
REQ-025 DMA in idle slot: CPU idle, dmaReq=1, dmaWrite=0, dmaAddr=16'h0200, memRData=16'h1234 -> dmaGnt=1 the same cycle, then dmaValid=1 and dmaRData=16'h1234 on the next cycle.
REQ-026 Starvation: CPU reads every cycle with dmaReq=1, dmaWrite=1, STARVE_LIMIT=8 -> dmaGnt=0 for 8 cycles; on the 9th cycle cpuStall=1, dmaGnt=1 and memWrite=1 at dmaAddr; CPU is served again on the 10th cycle.
REQ-027 Withdraw in FORCE: dmaReq drops to 0 on the FORCE cycle -> cpuStall=0, the CPU access is performed, and the FSM returns to ARB.
REQ-028 Simultaneous cpuRead=1 and cpuWrite=1 -> memWrite=1, memRead=0, memWData=cpuWData.
REQ-029 Reset mid-FORCE: reset=0 during FORCE -> next cycle state=ARB, starveCnt=0, dmaValid=0, cpuStall=0.
